// File: rtl/nms_frame_ctrl.sv
// nms_frame_ctrl: frame sequencer in front of NMS_top.
// Takes the FAST score/corner stream over a valid/ready handshake and numbers
// the pixels in raster order. It drives NMS_top's ce and input bus, then
// injects NMS_LAT flush pixels at frame end so the NMS line buffers drain.
// It qualifies the NMS outputs into a corner stream with a per-frame count.
//
// Optional build macro: NMS_FRAME_CTRL_BORDER_SUPPRESS_EN
//   When it is defined, pixels inside the radius-3 FAST border ring are never
//   offered to NMS_top as corners. Their score is still passed through.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for frame_start, no ce
//   RUN    | accepting pixels, one ce per handshake transfer
//   FLUSH  | NMS_LAT free-running ce cycles with blank pixels on row ROW_NUM
//   DONE   | one-cycle frame_done pulse, then back to IDLE
module nms_frame_ctrl #(
    parameter int COL_NUM = 640,
    parameter int ROW_NUM = 480,
    parameter int NMS_LAT = 642,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             pix_vld,
    output logic             pix_rdy,
    input  logic [12:0]      pix_score,
    input  logic             pix_corner,
    output logic             nms_ce,
    output logic [9:0]       nms_x,
    output logic [9:0]       nms_y,
    output logic             nms_iscorner,
    output logic [12:0]      nms_data,
    input  logic [9:0]       nms_x_out,
    input  logic [9:0]       nms_y_out,
    input  logic             nms_corner_out,
    output logic             corner_vld,
    output logic [9:0]       corner_x,
    output logic [9:0]       corner_y,
    output logic [CNT_W-1:0] corner_cnt,
    output logic             frame_done,
    output logic             busy
);

    localparam int CE_W = $clog2(NMS_LAT + 1);
    localparam logic [9:0]       X_LAST     = 10'(COL_NUM - 1);
    localparam logic [9:0]       Y_LAST     = 10'(ROW_NUM - 1);
    localparam logic [9:0]       FLUSH_ROW  = 10'(ROW_NUM);
    localparam logic [CE_W-1:0]  CE_MAX     = CE_W'(NMS_LAT);
    localparam logic [CE_W-1:0]  FLUSH_LOAD = CE_W'(NMS_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [9:0]      x_cnt;
    logic [9:0]      y_cnt;
    logic [CE_W-1:0] flush_cnt;
    logic [CE_W-1:0] ce_cnt;
    logic            xfer;
    logic            x_last;
    logic            y_last;
    logic            start_ok;
    logic            dec_vld;
    logic            border;

    assign xfer     = pix_vld & pix_rdy;
    assign x_last   = (x_cnt == X_LAST);
    assign y_last   = (y_cnt == Y_LAST);
    assign start_ok = (state == S_IDLE) & frame_start;
    // The first NMS_LAT ce cycles only prime the NMS pipeline.
    assign dec_vld  = nms_ce & (ce_cnt == CE_MAX);

`ifdef NMS_FRAME_CTRL_BORDER_SUPPRESS_EN
    assign border = (x_cnt < 10'd3) || (x_cnt >= 10'(COL_NUM - 3)) ||
                    (y_cnt < 10'd3) || (y_cnt >= 10'(ROW_NUM - 3));
`else
    assign border = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the combinational NMS-side bus.
    always_comb begin
        state_nxt    = state;
        pix_rdy      = 1'b0;
        nms_ce       = 1'b0;
        nms_x        = '0;
        nms_y        = '0;
        nms_iscorner = 1'b0;
        nms_data     = '0;
        busy         = 1'b0;
        frame_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_start) state_nxt = S_RUN;
            end
            S_RUN: begin
                pix_rdy      = 1'b1;
                busy         = 1'b1;
                nms_ce       = pix_vld;
                nms_x        = x_cnt;
                nms_y        = y_cnt;
                nms_data     = pix_score;
                nms_iscorner = pix_corner & ~border;
                if (pix_vld && x_last && y_last) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                busy   = 1'b1;
                nms_ce = 1'b1;
                nms_x  = x_cnt;
                nms_y  = FLUSH_ROW;
                if (flush_cnt == '0) state_nxt = S_DONE;
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Raster counters, flush down-counter and saturating ce count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            flush_cnt <= '0;
            ce_cnt    <= '0;
        end else if (start_ok) begin
            x_cnt  <= '0;
            y_cnt  <= '0;
            ce_cnt <= '0;
        end else begin
            if (nms_ce && (ce_cnt != CE_MAX)) ce_cnt <= ce_cnt + 1'b1;
            if (state == S_RUN && xfer) begin
                if (x_last) begin
                    x_cnt <= '0;
                    y_cnt <= y_last ? 10'd0 : y_cnt + 10'd1;
                end else begin
                    x_cnt <= x_cnt + 10'd1;
                end
                if (x_last && y_last) flush_cnt <= FLUSH_LOAD;
            end else if (state == S_FLUSH) begin
                x_cnt <= x_last ? 10'd0 : x_cnt + 10'd1;
                if (flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
            end
        end
    end

    // Registered corner stream; the count moves together with corner_vld.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corner_vld <= 1'b0;
            corner_x   <= '0;
            corner_y   <= '0;
            corner_cnt <= '0;
        end else begin
            corner_vld <= dec_vld & nms_corner_out;
            if (dec_vld && nms_corner_out) begin
                corner_x <= nms_x_out;
                corner_y <= nms_y_out;
            end
            if (start_ok) begin
                corner_cnt <= '0;
            end else if (dec_vld && nms_corner_out && (corner_cnt != CNT_MAX)) begin
                corner_cnt <= corner_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nms_frame_ctrl.sv
// Bench for nms_frame_ctrl on a small 8x6 frame with NMS_LAT=10.
// NMS_top is stood in for by a pure NMS_LAT-ce delay line. During priming it
// drives random garbage, including corner flags that must be discarded.
// Expected corners are the pixels flagged by the stimulus, in raster order.
module tb_nms_frame_ctrl;

    localparam int COL   = 8;
    localparam int ROW   = 6;
    localparam int LAT   = 10;
    localparam int CNT_W = 16;
    localparam int NPIX  = COL * ROW;

    logic             clk;
    logic             rst;
    logic             frame_start;
    logic             pix_vld;
    logic             pix_rdy;
    logic [12:0]      pix_score;
    logic             pix_corner;
    logic             nms_ce;
    logic [9:0]       nms_x;
    logic [9:0]       nms_y;
    logic             nms_iscorner;
    logic [12:0]      nms_data;
    logic [9:0]       nms_x_out;
    logic [9:0]       nms_y_out;
    logic             nms_corner_out;
    logic             corner_vld;
    logic [9:0]       corner_x;
    logic [9:0]       corner_y;
    logic [CNT_W-1:0] corner_cnt;
    logic             frame_done;
    logic             busy;

    nms_frame_ctrl #(
        .COL_NUM(COL),
        .ROW_NUM(ROW),
        .NMS_LAT(LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .pix_vld       (pix_vld),
        .pix_rdy       (pix_rdy),
        .pix_score     (pix_score),
        .pix_corner    (pix_corner),
        .nms_ce        (nms_ce),
        .nms_x         (nms_x),
        .nms_y         (nms_y),
        .nms_iscorner  (nms_iscorner),
        .nms_data      (nms_data),
        .nms_x_out     (nms_x_out),
        .nms_y_out     (nms_y_out),
        .nms_corner_out(nms_corner_out),
        .corner_vld    (corner_vld),
        .corner_x      (corner_x),
        .corner_y      (corner_y),
        .corner_cnt    (corner_cnt),
        .frame_done    (frame_done),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_err = 0;
    string cur_test = "reset";

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0d expected %0d", cur_test, tag, got, exp);
        end
    endtask

    // NMS_top stand-in: the decision for the pixel that entered LAT ces ago.
    logic [9:0] hist_x [0:63];
    logic [9:0] hist_y [0:63];
    logic       hist_c [0:63];
    int         ce_seen;
    logic       stub_clr;
    logic [9:0] garb_x;
    logic [9:0] garb_y;
    logic       garb_c;

    always @(posedge clk) begin
        garb_x <= 10'($urandom_range(1023));
        garb_y <= 10'($urandom_range(1023));
        garb_c <= 1'($urandom_range(1));
        if (stub_clr) begin
            ce_seen <= 0;
        end else if (nms_ce) begin
            if (ce_seen < 64) begin
                hist_x[6'(ce_seen)] <= nms_x;
                hist_y[6'(ce_seen)] <= nms_y;
                hist_c[6'(ce_seen)] <= nms_iscorner;
            end
            ce_seen <= ce_seen + 1;
        end
    end

    always_comb begin
        int k;
        k = ce_seen - LAT;
        if (k >= 0 && k < 64) begin
            nms_x_out      = hist_x[6'(k)];
            nms_y_out      = hist_y[6'(k)];
            nms_corner_out = hist_c[6'(k)];
        end else begin
            nms_x_out      = garb_x;
            nms_y_out      = garb_y;
            nms_corner_out = garb_c;
        end
    end

    // Reference pixel content for the current frame.
    logic [12:0] ref_score [NPIX];
    logic        ref_flag  [NPIX];

    function automatic bit exp_corner(input int t);
        bit c;
        c = ref_flag[t];
`ifdef NMS_FRAME_CTRL_BORDER_SUPPRESS_EN
        if ((t % COL) < 3 || (t % COL) >= COL - 3 || (t / COL) < 3 || (t / COL) >= ROW - 3)
            c = 1'b0;
`endif
        return c;
    endfunction

    // kind: 0 blank, 1 corner at (4,3), 2 random 30%, 3 corner at (1,1), 4 all corners
    task automatic set_pixels(input int kind);
        for (int t = 0; t < NPIX; t++) begin
            case (kind)
                0: begin ref_score[t] = '0; ref_flag[t] = 1'b0; end
                1: begin
                    ref_flag[t]  = (t == 3 * COL + 4);
                    ref_score[t] = ref_flag[t] ? 13'd100 : 13'd0;
                end
                2: begin
                    ref_flag[t]  = ($urandom_range(99) < 30);
                    ref_score[t] = 13'($urandom_range(8191));
                end
                3: begin
                    ref_flag[t]  = (t == 1 * COL + 1);
                    ref_score[t] = ref_flag[t] ? 13'd100 : 13'd0;
                end
                default: begin
                    ref_flag[t]  = 1'b1;
                    ref_score[t] = 13'($urandom_range(8191));
                end
            endcase
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pix_rdy"},      32'(pix_rdy), 0);
        chk({tag, "_nms_ce"},       32'(nms_ce), 0);
        chk({tag, "_nms_x"},        32'(nms_x), 0);
        chk({tag, "_nms_y"},        32'(nms_y), 0);
        chk({tag, "_nms_data"},     32'(nms_data), 0);
        chk({tag, "_nms_iscorner"}, 32'(nms_iscorner), 0);
        chk({tag, "_corner_vld"},   32'(corner_vld), 0);
        chk({tag, "_corner_x"},     32'(corner_x), 0);
        chk({tag, "_corner_y"},     32'(corner_y), 0);
        chk({tag, "_corner_cnt"},   32'(corner_cnt), 0);
        chk({tag, "_frame_done"},   32'(frame_done), 0);
        chk({tag, "_busy"},         32'(busy), 0);
    endtask

    // vld_mode: 0 always valid, 1 every other cycle, 2 random 60%
    task automatic run_frame(input int vld_mode, input bit mid_start, input bit rst_flush);
        int idx, flush_n, ce_tot, done_n, cyc, n_exp, post;
        int qx[$];
        int qy[$];
        bit fin, exp_ce, exp_done;
        idx = 0; flush_n = 0; ce_tot = 0; done_n = 0; cyc = 0; post = 0; fin = 0;
        for (int t = 0; t < NPIX; t++) begin
            if (exp_corner(t)) begin
                qx.push_back(t % COL);
                qy.push_back(t / COL);
            end
        end
        n_exp = qx.size();

        @(negedge clk);
        frame_start = 1'b1; stub_clr = 1'b1; pix_vld = 1'b0;
        @(negedge clk);
        frame_start = 1'b0; stub_clr = 1'b0;

        while (post < 3 && cyc < 1000) begin
            if (idx < NPIX) begin
                case (vld_mode)
                    0:       pix_vld = 1'b1;
                    1:       pix_vld = (cyc % 2 == 0);
                    default: pix_vld = ($urandom_range(99) < 60);
                endcase
                pix_score  = ref_score[idx];
                pix_corner = ref_flag[idx];
            end else begin
                pix_vld    = 1'($urandom_range(1));
                pix_score  = 13'($urandom_range(8191));
                pix_corner = 1'b1;
            end
            frame_start = mid_start && (cyc == 17);
            #1;
            if (corner_vld) begin
                if (qx.size() == 0) begin
                    chk("spurious_corner", 1, 0);
                end else begin
                    chk("corner_x", 32'(corner_x), 32'(qx.pop_front()));
                    chk("corner_y", 32'(corner_y), 32'(qy.pop_front()));
                end
            end
            if (fin) begin
                chk("done_pulse", 32'(frame_done), 0);
                chk("idle_busy",  32'(busy), 0);
                chk("idle_ce",    32'(nms_ce), 0);
                chk("idle_rdy",   32'(pix_rdy), 0);
                post++;
            end else begin
                exp_ce   = (idx < NPIX) ? pix_vld : (flush_n < LAT);
                exp_done = (idx == NPIX) && (flush_n == LAT);
                chk("pix_rdy",    32'(pix_rdy), 32'(idx < NPIX));
                chk("busy",       32'(busy), 32'(!exp_done));
                chk("nms_ce",     32'(nms_ce), 32'(exp_ce));
                chk("frame_done", 32'(frame_done), 32'(exp_done));
                if (pix_vld && pix_rdy && idx < NPIX) begin
                    chk("nms_x",        32'(nms_x), 32'(idx % COL));
                    chk("nms_y",        32'(nms_y), 32'(idx / COL));
                    chk("nms_data",     32'(nms_data), 32'(ref_score[idx]));
                    chk("nms_iscorner", 32'(nms_iscorner), 32'(exp_corner(idx)));
                    idx++;
                end else if (nms_ce && idx == NPIX) begin
                    chk("flush_y",        32'(nms_y), ROW);
                    chk("flush_data",     32'(nms_data), 0);
                    chk("flush_iscorner", 32'(nms_iscorner), 0);
                    flush_n++;
                end
                if (nms_ce) ce_tot++;
                if (frame_done) begin
                    done_n++;
                    fin = 1'b1;
                    chk("corners_left_at_done", 32'(qx.size()), 0);
                end
            end
            if (rst_flush && flush_n == 3 && !fin) begin
                rst = 1'b1;
                #1;
                chk_all_zero("rst_in_flush");
                @(negedge clk);
                rst = 1'b0; frame_start = 1'b0; pix_vld = 1'b0;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        frame_start = 1'b0;
        pix_vld     = 1'b0;
        if (post < 3) chk("timeout", 1, 0);
        chk("ce_total",   32'(ce_tot), NPIX + LAT);
        chk("done_count", 32'(done_n), 1);
        chk("corners_missing", 32'(qx.size()), 0);
        chk("corner_cnt", 32'(corner_cnt), 32'(n_exp));
    endtask

    initial begin
        rst         = 1'b1;
        stub_clr    = 1'b1;
        frame_start = 1'b0;
        pix_vld     = 1'b0;
        pix_score   = '0;
        pix_corner  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        cur_test = "blank";         set_pixels(0); run_frame(0, 1'b0, 1'b0);
        cur_test = "single";        set_pixels(1); run_frame(0, 1'b0, 1'b0);
        cur_test = "single_toggle";                run_frame(1, 1'b0, 1'b0);
        cur_test = "mid_start";     set_pixels(2); run_frame(0, 1'b1, 1'b0);
        cur_test = "rst_flush";     set_pixels(4); run_frame(2, 1'b0, 1'b1);
        cur_test = "after_rst";     set_pixels(2); run_frame(2, 1'b0, 1'b0);
        cur_test = "corner_1_1";    set_pixels(3); run_frame(0, 1'b0, 1'b0);
        cur_test = "all_corners";   set_pixels(4); run_frame(2, 1'b0, 1'b0);
        cur_test = "random";        set_pixels(2); run_frame(2, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nms_frame_ctrl.md
Name: nms_frame_ctrl

Overview:
- Frame sequencer in front of NMS_top.
- Accepts the FAST detector's per-pixel score/corner stream over a valid/ready handshake, generates raster x/y coordinates, and drives NMS_top's ce and input bus.
- At frame end it injects flush pixels so the NMS line buffers drain.
- Qualifies NMS_top outputs into a corner stream with a per-frame corner count and a done pulse.

Parameters:
- COL_NUM, 640, pixels per line; must match NMS_top COL_NUM.
- ROW_NUM, 480, lines per frame.
- NMS_LAT, 642, ce cycles from a pixel entering NMS_top to its NMS decision appearing at corner_out (COL_NUM+2 for NMS_SIZE=3).
- CNT_W, 16, corner counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- frame_start  in  1  single-cycle pulse; arms a new frame
- pix_vld  in  1  input pixel valid
- pix_rdy  out  1  input pixel ready
- pix_score  in  13  FAST corner score
- pix_corner  in  1  FAST corner flag
- nms_ce  out  1  clock enable to NMS_top
- nms_x  out  10  x_coord_in to NMS_top
- nms_y  out  10  y_coord_in to NMS_top
- nms_iscorner  out  1  iscorner to NMS_top
- nms_data  out  13  data_in to NMS_top
- nms_x_out  in  10  x_coord_out from NMS_top
- nms_y_out  in  10  y_coord_out from NMS_top
- nms_corner_out  in  1  corner_out from NMS_top
- corner_vld  out  1  qualified corner strobe
- corner_x  out  10  corner x
- corner_y  out  10  corner y
- corner_cnt  out  CNT_W  corners emitted this frame, saturating
- frame_done  out  1  single-cycle pulse after last corner of frame
- busy  out  1  high in RUN or FLUSH

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0. Counters x, y, flush, ce-count cleared.
- FSM IDLE: pix_rdy=0, nms_ce=0. frame_start -> RUN; x, y, ce-count and corner_cnt cleared on that edge.
- FSM RUN: pix_rdy=1.
  - Each cycle with pix_vld&pix_rdy, nms_ce=1 the same cycle (combinational from the handshake). nms_x/nms_y carry the current counters; nms_data=pix_score; nms_iscorner=pix_corner.
  - x increments and wraps at COL_NUM-1 to 0, incrementing y.
  - Transfer of pixel (COL_NUM-1, ROW_NUM-1) -> FLUSH.
  - No ce without a transfer (pipeline stalls with input).
- FSM FLUSH: pix_rdy=0. nms_ce=1 every cycle for exactly NMS_LAT cycles.
  - nms_iscorner=0, nms_data=0.
  - nms_y=ROW_NUM, nms_x counting 0.. (values don't matter; never corners).
  - After the last flush ce -> DONE.
- FSM DONE: one cycle. frame_done=1, then -> IDLE.
- frame_start outside IDLE is ignored.
- ce-count: counts nms_ce cycles since frame_start, saturating at NMS_LAT.
- Output qualification:
  - A decision is valid on an nms_ce cycle once ce-count >= NMS_LAT; earlier outputs are priming garbage and are discarded.
  - On a valid ce cycle with nms_corner_out=1, the next cycle gives corner_vld=1, corner_x=nms_x_out, corner_y=nms_y_out (registered, latency 1).
  - corner_vld otherwise 0. corner_x/corner_y hold their last value.
- corner_cnt increments on each corner_vld and saturates at 2^CNT_W-1. It holds through IDLE until the next frame_start.
- frame_done fires in DONE, after the final registered corner_vld (the last flush ce decides pixel (COL_NUM-1, ROW_NUM-1); its corner_vld coincides with the DONE entry cycle at the latest).
- busy=1 in RUN and FLUSH.
- Total frame input ce cycles = COL_NUM*ROW_NUM + NMS_LAT.

Optional Feature:
- NMS_FRAME_CTRL_BORDER_SUPPRESS_EN defined: in RUN, nms_iscorner is forced 0 when x<3, x>=COL_NUM-3, y<3 or y>=ROW_NUM-3. This excludes the FAST radius-3 ring border. nms_data is still passed unmodified.
- Undefined: nms_iscorner=pix_corner always.

Test Plan (COL_NUM=8, ROW_NUM=6, NMS_LAT=10 for sim):
- Reset, frame_start, 48 pixels pix_vld=1 all pix_corner=0 -> exactly 58 nms_ce cycles, corner_vld never 1, frame_done one pulse, corner_cnt=0.
- Single corner at (4,3) score 100, rest score 0/corner 0 -> one corner_vld with corner_x=4, corner_y=3; corner_cnt=1.
- pix_vld toggling every other cycle -> nms_ce only on transfers; same (4,3) result as the previous test; x/y wrap 7->0 with y increment.
- frame_start asserted mid-RUN -> ignored; frame completes normally, corner_cnt not cleared.
- rst asserted during FLUSH -> next cycle all outputs 0, state IDLE; a new frame_start then runs a full frame correctly.
- With NMS_FRAME_CTRL_BORDER_SUPPRESS_EN, corner at (1,1) -> corner_cnt=0. Without the macro, NMS_top decides whether it is emitted.
